// File: rtl/simd_dispatch.sv
// simd_dispatch: issue/writeback stage feeding a lane-segmented SIMD adder.
// Define SIMD_DISPATCH_BYPASS_EN to forward writeback data instead of stalling dependent issues.
module simd_dispatch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_instr,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] simd_a,
    output logic [15:0] simd_b,
    output logic        simd_h,
    output logic        simd_o,
    output logic        simd_q,
    output logic        simd_sub,
    input  logic [15:0] simd_sum,
    output logic [15:0] res_data,
    output logic [2:0]  res_rd,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        err_illegal
);
    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;
    localparam logic [1:0] OP_LDI = 2'd3;

    logic        i_valid;
    logic [1:0]  i_op;
    logic [1:0]  i_mode;
    logic [2:0]  i_rd;
    logic [15:0] i_a;
    logic [15:0] i_b;
    logic        r_valid;
    logic [2:0]  r_rd;
    logic [15:0] r_data;
    logic        err;
    logic [15:0] rf [8];

    logic [1:0]  op;
    logic [1:0]  mode;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        is_arith;
    logic        is_illegal;
    logic        adv;
    logic        hazard;
    logic        xfer;
    logic        load;
    logic        act;
    logic [15:0] wb_data;
    logic [15:0] opa;
    logic [15:0] opb;

    assign op         = in_instr[15:14];
    assign mode       = in_instr[13:12];
    assign rd         = in_instr[11:9];
    assign rs1        = in_instr[8:6];
    assign rs2        = in_instr[5:3];
    assign is_arith   = (op == OP_ADD) || (op == OP_SUB);
    assign is_illegal = is_arith && (mode == 2'b11);

    assign adv      = i_valid && (!r_valid || res_ready);
    assign wb_data  = (i_op == OP_LDI) ? i_a : simd_sum;
    assign in_ready = (!i_valid || adv) && !hazard;
    assign xfer     = in_valid && in_ready;
    assign load     = xfer && (op != OP_NOP) && !is_illegal;

    always_comb begin
`ifdef SIMD_DISPATCH_BYPASS_EN
        hazard = 1'b0;
        opa    = (adv && rs1 == i_rd) ? wb_data : rf[rs1];
        opb    = (adv && rs2 == i_rd) ? wb_data : rf[rs2];
`else
        // Dependent ADD/SUB waits one cycle so the regfile holds the fresh value.
        hazard = in_valid && is_arith && i_valid && (rs1 == i_rd || rs2 == i_rd);
        opa    = rf[rs1];
        opb    = rf[rs2];
`endif
    end

    // The adder only sees a live ADD/SUB; LDI and empty slots drive all zeros.
    assign act      = i_valid && (i_op != OP_LDI);
    assign simd_a   = act ? i_a : 16'h0;
    assign simd_b   = act ? i_b : 16'h0;
    assign simd_h   = act && (i_mode == 2'b10);
    assign simd_o   = act && (i_mode == 2'b01);
    assign simd_q   = act && (i_mode == 2'b00);
    assign simd_sub = act && (i_op == OP_SUB);

    assign res_data    = r_data;
    assign res_rd      = r_rd;
    assign res_valid   = r_valid;
    assign err_illegal = err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_valid <= 1'b0;
            i_op    <= OP_NOP;
            i_mode  <= 2'b00;
            i_rd    <= 3'd0;
            i_a     <= 16'h0;
            i_b     <= 16'h0;
        end else if (load) begin
            i_valid <= 1'b1;
            i_op    <= op;
            i_mode  <= mode;
            i_rd    <= rd;
            i_a     <= (op == OP_LDI) ? {7'd0, in_instr[8:0]} : opa;
            i_b     <= (op == OP_LDI) ? 16'h0 : opb;
        end else if (adv) begin
            i_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_rd    <= 3'd0;
            r_data  <= 16'h0;
            err     <= 1'b0;
            for (int i = 0; i < 8; i++) rf[i] <= 16'h0;
        end else begin
            err <= xfer && is_illegal;
            if (adv) begin
                r_valid  <= 1'b1;
                r_rd     <= i_rd;
                r_data   <= wb_data;
                rf[i_rd] <= wb_data;
            end else if (res_ready && r_valid) begin
                r_valid <= 1'b0;
            end
        end
    end
endmodule
